// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared FSM state encoding and op codes for the ALU add/sub path
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_sub.sv
// rtl/add_sub.sv - combinational adder/subtractor with carry/borrow input
module add_sub #(
    parameter int DATA_SIZE = 17
) (
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    input  logic                 cin,
    input  logic                 operation,
    output logic [DATA_SIZE-1:0] s
);

    // operation=1: a+b+cin; operation=0: a-b-cin (cin acts as borrow-in)
    always_comb begin
        s = '0;
        if (operation) begin
            s = a + b + DATA_SIZE'(cin);
        end else begin
            s = a - b - DATA_SIZE'(cin);
        end
    end

endmodule

// File: rtl/addsub_mp_seq.sv
// rtl/addsub_mp_seq.sv - multi-precision add/subtract sequencer over one shared word adder
module addsub_mp_seq
    import alu_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int NUM_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        op_sub,
    input  logic [WORD_W*NUM_WORDS-1:0] a,
    input  logic [WORD_W*NUM_WORDS-1:0] b,
    input  logic                        abort,
    output logic                        ready,
    output logic                        busy,
    output logic                        done,
    output logic [WORD_W*NUM_WORDS-1:0] result,
    output logic                        cout,
    output logic                        overflow
);

    localparam int TOT_W = WORD_W * NUM_WORDS;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [TOT_W-1:0]   a_r;
    logic [TOT_W-1:0]   b_r;
    logic               op_sub_r;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WORD_W-1:0]  a_word;
    logic [WORD_W-1:0]  b_word;
    logic [WORD_W-1:0]  b_eff;
    logic [WORD_W:0]    s;
    logic               last;

    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (idx == IDX_W'(w)) begin
                a_word = a_r[w*WORD_W +: WORD_W];
                b_word = b_r[w*WORD_W +: WORD_W];
            end
        end
    end

    // Subtraction is a + ~b + 1: the +1 comes from the carry seeded at start
    assign b_eff = b_word ^ {WORD_W{op_sub_r}};
    assign last  = (idx == LAST_IDX);

    add_sub #(
        .DATA_SIZE(WORD_W + 1)
    ) u_add_sub (
        .a        ({1'b0, a_word}),
        .b        ({1'b0, b_eff}),
        .cin      (carry),
        .operation(1'b1),
        .s        (s)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            op_sub_r <= OP_ADD;
            idx      <= '0;
            carry    <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r      <= a;
                        b_r      <= b;
                        op_sub_r <= op_sub;
                        idx      <= '0;
                        carry    <= (op_sub == OP_SUB);
                    end
                end
                RUN: begin
                    if (!abort) begin
                        for (int w = 0; w < NUM_WORDS; w++) begin
                            if (idx == IDX_W'(w)) begin
                                result[w*WORD_W +: WORD_W] <= s[WORD_W-1:0];
                            end
                        end
                        carry <= s[WORD_W];
                        idx   <= idx + 1'b1;
                        if (last) begin
                            cout     <= s[WORD_W];
                            overflow <= (a_word[WORD_W-1] == b_eff[WORD_W-1]) &&
                                        (s[WORD_W-1] != a_word[WORD_W-1]);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_mp_seq.sv
// tb/tb_addsub_mp_seq.sv - self-checking bench for addsub_mp_seq
module tb_addsub_mp_seq;

    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = 4;
    localparam int TOT_W     = WORD_W * NUM_WORDS;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             op_sub;
    logic [TOT_W-1:0] a;
    logic [TOT_W-1:0] b;
    logic             abort;
    logic             ready;
    logic             busy;
    logic             done;
    logic [TOT_W-1:0] result;
    logic             cout;
    logic             overflow;

    int total;
    int bad;

    addsub_mp_seq #(
        .WORD_W   (WORD_W),
        .NUM_WORDS(NUM_WORDS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_sub  (op_sub),
        .a       (a),
        .b       (b),
        .abort   (abort),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TOT_W-1:0] va;
        logic [TOT_W-1:0] vb;
        logic             vsub;
        logic [TOT_W-1:0] eres;
        logic             ecout;
        logic             eovf;
    } vec_t;

    task automatic chk(input string name, input logic [TOT_W-1:0] act, input logic [TOT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide signed/unsigned arithmetic
    task automatic model(input logic [TOT_W-1:0] ma, input logic [TOT_W-1:0] mb, input logic msub,
                         output logic [TOT_W-1:0] r, output logic co, output logic ov);
        logic signed [TOT_W+1:0] sa;
        logic [TOT_W:0]          ua;
        if (msub) begin
            sa = $signed({ma[TOT_W-1], ma[TOT_W-1], ma}) - $signed({mb[TOT_W-1], mb[TOT_W-1], mb});
            co = (ma >= mb);
            r  = ma - mb;
        end else begin
            sa = $signed({ma[TOT_W-1], ma[TOT_W-1], ma}) + $signed({mb[TOT_W-1], mb[TOT_W-1], mb});
            ua = {1'b0, ma} + {1'b0, mb};
            co = ua[TOT_W];
            r  = ua[TOT_W-1:0];
        end
        ov = (sa > $signed({2'b00, 1'b0, {(TOT_W-1){1'b1}}})) ||
             (sa < -$signed({2'b00, 1'b1, {(TOT_W-1){1'b0}}}));
    endtask

    // Launch one operation and wait for done; lat counts negedges after the accept edge
    task automatic run_op(input logic [TOT_W-1:0] ta, input logic [TOT_W-1:0] tb2, input logic tsub,
                          input logic with_abort, output logic [TOT_W-1:0] r, output logic co,
                          output logic ov, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        a      = ta;
        b      = tb2;
        op_sub = tsub;
        start  = 1'b1;
        abort  = with_abort;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        lat   = 0;
        r     = '0;
        co    = 1'b0;
        ov    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                r  = result;
                co = cout;
                ov = overflow;
                break;
            end
        end
        if (!done) begin
            lat = -1;
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic [TOT_W-1:0] r;
        logic [TOT_W-1:0] er;
        logic [TOT_W-1:0] ra;
        logic [TOT_W-1:0] rb;
        logic             co;
        logic             ov;
        logic             eco;
        logic             eov;
        logic             rs;
        int               lat;
        int               ndone;
        int               ready_low_bad;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op_sub = 1'b0;
        a     = '0;
        b     = '0;
        abort = 1'b0;

        vecs.push_back('{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0});
        vecs.push_back('{64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{64'h5, 64'h3, 1'b1, 64'h2, 1'b1, 1'b0});
        vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0});
        vecs.push_back('{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h0, 1'b1, 1'b0});

        #12;
        chk("reset_ready", {63'd0, ready}, 64'd1);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_cout", {63'd0, cout}, 64'd0);
        chk("reset_ovf", {63'd0, overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, 1'b0, r, co, ov, lat);
            chk($sformatf("vec%0d_result", i), r, vecs[i].eres);
            chk($sformatf("vec%0d_cout", i), {63'd0, co}, {63'd0, vecs[i].ecout});
            chk($sformatf("vec%0d_ovf", i), {63'd0, ov}, {63'd0, vecs[i].eovf});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(NUM_WORDS + 1));
            @(negedge clk);
            chk($sformatf("vec%0d_done_width", i), {63'd0, done}, 64'd0);
            chk($sformatf("vec%0d_ready_after", i), {63'd0, ready}, 64'd1);
        end

        // start and abort together in IDLE: start wins
        run_op(64'h10, 64'h20, 1'b0, 1'b1, r, co, ov, lat);
        chk("start_abort_result", r, 64'h30);
        chk("start_abort_latency", 64'(lat), 64'(NUM_WORDS + 1));

        // Second start during RUN is ignored; ready stays low until after done
        @(negedge clk);
        a = 64'h0000_0001_0000_0001; b = 64'h0000_0002_0000_0002; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 64'hDEAD_BEEF_DEAD_BEEF; b = 64'h1111_1111_1111_1111; op_sub = 1'b1;
        ndone = 0;
        ready_low_bad = 0;
        for (int i = 0; i < NUM_WORDS + 1; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (ready) ready_low_bad++;
            if (done) begin
                ndone++;
                r = result;
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("hs_ready_back", {63'd0, ready}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("hs_ready_low", 64'(ready_low_bad), 64'd0);
        chk("hs_done_count", 64'(ndone), 64'd1);
        chk("hs_result", r, 64'h0000_0003_0000_0003);
        chk("hs_result_held", result, 64'h0000_0003_0000_0003);

        // Abort at idx=2: no done, back to IDLE, cout/overflow untouched
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, r, co, ov, lat);
        chk("pre_abort_cout", {63'd0, co}, 64'd1);
        @(negedge clk);
        a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'h1; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_ready", {63'd0, ready}, 64'd1);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        chk("abort_cout_kept", {63'd0, cout}, 64'd1);
        chk("abort_ovf_kept", {63'd0, overflow}, 64'd0);
        run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, r, co, ov, lat);
        chk("post_abort_result", r, 64'h0001_0000_0001_0000);

        // Randomized against the wide-arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) rb = ~ra;
            model(ra, rb, rs, er, eco, eov);
            run_op(ra, rb, rs, 1'b0, r, co, ov, lat);
            chk($sformatf("rand%0d_result", i), r, er);
            chk($sformatf("rand%0d_cout", i), {63'd0, co}, {63'd0, eco});
            chk($sformatf("rand%0d_ovf", i), {63'd0, ov}, {63'd0, eov});
        end

        // Asynchronous reset mid-RUN
        @(negedge clk);
        a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", {63'd0, ready}, 64'd1);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_done", {63'd0, done}, 64'd0);
        chk("rst_mid_result", result, 64'd0);
        chk("rst_mid_cout", {63'd0, cout}, 64'd0);
        chk("rst_mid_ovf", {63'd0, overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(64'h5, 64'h7, 1'b1, 1'b0, r, co, ov, lat);
        chk("post_rst_result", r, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("post_rst_cout", {63'd0, co}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_mp_seq.md
Name: addsub_mp_seq

Overview:
- Multi-precision add/subtract sequencer.
- Accepts full-width operands (NUM_WORDS x WORD_W bits) with a start pulse.
- Runs one word per cycle, LSW first, through a single shared add_sub instance, holding the inter-word carry in a register.
- Sits between ALU control and the add_sub datapath, so wide (default 64-bit) arithmetic reuses one 16-bit adder.

Parameters:
- WORD_W, 16, width of one datapath word.
- NUM_WORDS, 4, words per operand; total width TOT_W = WORD_W*NUM_WORDS; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while ready=1
- op_sub  input  1  1 = a-b, 0 = a+b; captured with start
- a  input  TOT_W  operand A; captured with start
- b  input  TOT_W  operand B; captured with start
- abort  input  1  synchronous cancel of a running operation
- ready  output  1  idle, start accepted
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result valid
- result  output  TOT_W  sum/difference, held until next accepted start
- cout  output  1  final carry out; for subtraction 1 = no borrow (a>=b unsigned)
- overflow  output  1  signed two's-complement overflow of the full-width result

Behaviour:
- Reset (rst_n=0, async): state IDLE, ready=1, busy=0, done=0, result=0, cout=0, overflow=0, word index=0, carry register=0, operand registers=0.
- FSM states:
  - IDLE: ready=1. start=1 -> capture a, b, op_sub; idx=0; carry=op_sub; go RUN.
  - RUN: busy=1, ready=0.
    - Each cycle: word idx of a is added to (word idx of b XOR {WORD_W{op_sub_r}}) plus carry.
    - Sum is written into word idx of result; carry <= word carry-out; idx++.
    - On idx=NUM_WORDS-1, also latch cout and overflow, then go DONE.
  - DONE: done=1 for exactly one cycle, busy=0, ready=0; next cycle IDLE.
- Latency: start sampled at edge N -> done high in cycle N+NUM_WORDS+1; ready again at N+NUM_WORDS+2. Throughput is one operation per NUM_WORDS+2 cycles.
- Datapath use:
  - add_sub instantiated with DATA_SIZE = WORD_W+1, operation tied to 1 (add mode).
  - Inputs are zero-extended words; cin = carry register.
  - Word sum = s[WORD_W-1:0]; word carry-out = s[WORD_W]. The inversion for subtraction is done here, not in add_sub.
- Overflow: on the last word, with aw = A MSB and bw = inverted-or-not B MSB, overflow = (aw == bw) && (sum MSB != aw).
- Boundary conditions:
  - start while busy or in DONE: ignored, no queueing; a and b changes during RUN have no effect.
  - abort in RUN: next state IDLE, no done pulse. result keeps the partially written words and is undefined for use. cout and overflow are not updated.
  - abort in IDLE or DONE: no effect; DONE still pulses.
  - start and abort together in IDLE: start wins.
  - Wrap-around: a+b beyond 2^TOT_W truncates, cout=1. a-b with a<b gives the two's-complement result, cout=0.
  - NUM_WORDS=1: RUN lasts one cycle.
  - rst_n asserted mid-RUN: immediate return to reset values.

Decomposition:
- Shared package alu_pkg holds the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the op code constants OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module: add_sub (existing), a single instance.
- Word select/insert logic, carry register and FSM stay in addsub_mp_seq; no other sub-modules.

Test Plan:
- Add with carry chain:
  - Stimulus: a=64'h0000_0000_FFFF_FFFF, b=64'h1, op_sub=0.
  - Response: result=64'h0000_0001_0000_0000, cout=0, overflow=0, done at cycle 5 after start.
- Subtract with borrow:
  - Stimulus: a=64'h0, b=64'h1, op_sub=1.
  - Response: result=64'hFFFF_FFFF_FFFF_FFFF, cout=0, overflow=0. Then a=64'h5, b=64'h3 -> result=2, cout=1.
- Signed overflow:
  - Stimulus: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, add.
  - Response: result=64'h8000_0000_0000_0000, overflow=1, cout=0. Also 64'h8000_0000_0000_0000 - 1 -> overflow=1, cout=1.
- Full wrap:
  - Stimulus: a=b=64'hFFFF_FFFF_FFFF_FFFF, add.
  - Response: result=64'hFFFF_FFFF_FFFF_FFFE, cout=1, overflow=0.
- Handshake:
  - Stimulus: second start pulse during RUN with different operands.
  - Response: ignored, first result unchanged, exactly one done pulse, ready low from the accept edge until the cycle after done.
- Abort and reset:
  - Stimulus: abort in RUN at idx=2.
  - Response: no done, ready=1 next cycle, a fresh start then completes correctly. rst_n low mid-RUN -> all outputs at reset values asynchronously.
